// File: rtl/adc_fill_pkg.sv
// Shared types and constants for the ADC fill sequencer: FSM states, burst
// lengths and default widths.
package adc_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } fill_state_e;

    localparam int unsigned BURST_LEN_8    = 8;
    localparam int unsigned BURST_LEN_10   = 10;
    localparam int unsigned CNT_W_DEFAULT  = 21;
    localparam int unsigned DATA_W_DEFAULT = 12;
    localparam int unsigned SMP_CNT_W      = 4;

    // Index of the last sample in a burst for the selected burst length.
    function automatic logic [SMP_CNT_W-1:0] last_sample_idx(input logic sel_10);
        logic [SMP_CNT_W-1:0] idx_s;
        if (sel_10) begin
            idx_s = SMP_CNT_W'(BURST_LEN_10 - 1);
        end else begin
            idx_s = SMP_CNT_W'(BURST_LEN_8 - 1);
        end
        return idx_s;
    endfunction

endpackage

// File: rtl/adc_fill_sequencer_if.sv
// Sample-stream / FIFO-write bundle between the ADC front end, the fill
// sequencer and the channel fill FIFO.
interface adc_fill_sequencer_if #(
    parameter int DATA_W = 12
) ();
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;
    logic              fifo_ready;
    logic              fifo_wr;
    logic [DATA_W-1:0] fifo_data;

    modport master (
        output adc_valid,
        output adc_data,
        output fifo_ready,
        input  fifo_wr,
        input  fifo_data
    );

    modport slave (
        input  adc_valid,
        input  adc_data,
        input  fifo_ready,
        output fifo_wr,
        output fifo_data
    );
endinterface

// File: rtl/fill_burst_down_cntr.sv
// Loadable remaining-burst down-counter; decrements saturate at zero so the
// count never wraps.
module fill_burst_down_cntr #(
    parameter int CNT_W = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec_en,
    output logic [CNT_W-1:0] count,
    output logic             at_zero
);

    logic [CNT_W-1:0] count_r;
    logic             zero_s;

    assign zero_s  = (count_r == {CNT_W{1'b0}});
    assign count   = count_r;
    assign at_zero = zero_s;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec_en && !zero_s) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/adc_fill_sequencer.sv
// Per-channel fill controller: gates a programmed number of complete 8/10
// sample bursts from the ADC stream into the fill FIFO and reports status.
module adc_fill_sequencer
    import adc_fill_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 armed,
    input  logic                 trigger,
    input  logic                 abort,
    input  logic                 clear_status,
    input  logic [CNT_W-1:0]     num_fill_bursts,
    input  logic                 burst_sel_10,
    adc_fill_sequencer_if.slave  stream,
    output logic                 busy,
    output logic                 fill_done,
    output logic                 fill_aborted,
    output logic [CNT_W-1:0]     bursts_left,
    output logic                 overflow,
    output logic                 trig_miss
);

    fill_state_e          state_r, state_s;
    logic                 sel_10_r;
    logic [SMP_CNT_W-1:0] smp_cnt_r;
    logic                 fifo_wr_r;
    logic [DATA_W-1:0]    fifo_data_r;
    logic                 busy_r, done_r, aborted_r, overflow_r, trig_miss_r;

    logic                 trig_accept_s, abort_hit_s, take_s, drop_s;
    logic                 burst_end_s, last_burst_s, cnt_zero_s;
    logic [CNT_W-1:0]     cnt_s;

    assign trig_accept_s = (state_r == IDLE) && trigger && armed;
    assign abort_hit_s   = abort && ((state_r == LOAD) || (state_r == FILL));
    // An abort suppresses the acceptance of the sample in the same cycle.
    assign take_s        = (state_r == FILL) && stream.adc_valid && stream.fifo_ready && !abort;
    assign drop_s        = (state_r == FILL) && stream.adc_valid && !stream.fifo_ready;
    assign burst_end_s   = take_s && (smp_cnt_r == last_sample_idx(sel_10_r));
    assign last_burst_s  = burst_end_s && (cnt_s == {{(CNT_W-1){1'b0}}, 1'b1});

    fill_burst_down_cntr #(
        .CNT_W (CNT_W)
    ) u_down_cntr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (trig_accept_s),
        .load_val (num_fill_bursts),
        .dec_en   (burst_end_s),
        .count    (cnt_s),
        .at_zero  (cnt_zero_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (trig_accept_s) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (cnt_zero_s) begin
                    state_s = DONE;
                end else begin
                    state_s = FILL;
                end
            end
            FILL: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (last_burst_s) begin
                    state_s = DONE;
                end else begin
                    state_s = FILL;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Burst-length select and in-burst sample counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_10_r  <= 1'b0;
            smp_cnt_r <= {SMP_CNT_W{1'b0}};
        end else if (trig_accept_s) begin
            sel_10_r  <= burst_sel_10;
            smp_cnt_r <= {SMP_CNT_W{1'b0}};
        end else if (burst_end_s) begin
            sel_10_r  <= sel_10_r;
            smp_cnt_r <= {SMP_CNT_W{1'b0}};
        end else if (take_s) begin
            sel_10_r  <= sel_10_r;
            smp_cnt_r <= smp_cnt_r + {{(SMP_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            sel_10_r  <= sel_10_r;
            smp_cnt_r <= smp_cnt_r;
        end
    end

    // Registered FIFO write path and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_r   <= 1'b0;
            fifo_data_r <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            aborted_r   <= 1'b0;
        end else begin
            fifo_wr_r   <= take_s;
            fifo_data_r <= take_s ? stream.adc_data : fifo_data_r;
            busy_r      <= (state_s == LOAD) || (state_s == FILL);
            done_r      <= (state_s == DONE);
            aborted_r   <= abort_hit_s;
        end
    end

    // Sticky status flags; a set in the same cycle beats any clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            trig_miss_r <= 1'b0;
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (trig_accept_s || clear_status) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (trigger && (state_r != IDLE)) begin
                trig_miss_r <= 1'b1;
            end else if (trig_accept_s || clear_status) begin
                trig_miss_r <= 1'b0;
            end else begin
                trig_miss_r <= trig_miss_r;
            end
        end
    end

    assign stream.fifo_wr   = fifo_wr_r;
    assign stream.fifo_data = fifo_data_r;
    assign busy             = busy_r;
    assign fill_done        = done_r;
    assign fill_aborted     = aborted_r;
    assign bursts_left      = cnt_s;
    assign overflow         = overflow_r;
    assign trig_miss        = trig_miss_r;

endmodule

// File: tb/tb_adc_fill_sequencer.sv
// Self-checking bench for adc_fill_sequencer: directed scenarios plus random
// traffic, compared every cycle against a sample-counting reference model.
module tb_adc_fill_sequencer;

    localparam int CNT_W  = 21;
    localparam int DATA_W = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             armed = 1'b0;
    logic             trigger = 1'b0;
    logic             abort = 1'b0;
    logic             clear_status = 1'b0;
    logic [CNT_W-1:0] num_fill_bursts = '0;
    logic             burst_sel_10 = 1'b0;
    logic             busy, fill_done, fill_aborted, overflow, trig_miss;
    logic [CNT_W-1:0] bursts_left;

    adc_fill_sequencer_if #(.DATA_W(DATA_W)) ifc ();

    adc_fill_sequencer #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .armed           (armed),
        .trigger         (trigger),
        .abort           (abort),
        .clear_status    (clear_status),
        .num_fill_bursts (num_fill_bursts),
        .burst_sel_10    (burst_sel_10),
        .stream          (ifc.slave),
        .busy            (busy),
        .fill_done       (fill_done),
        .fill_aborted    (fill_aborted),
        .bursts_left     (bursts_left),
        .overflow        (overflow),
        .trig_miss       (trig_miss)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a fill is N*L accepted samples; bursts_left = N - acc/L.
    bit          m_act, m_ld;
    int          m_n, m_len, m_acc;
    logic        e_wr, e_busy, e_done, e_abt, e_ovf, e_tm;
    logic [11:0] e_data;
    logic [20:0] e_bl;

    // Observed event counters for directed checks.
    int wr_cnt, busy_cnt, done_cnt, abt_cnt, done_at_wr;

    task automatic check_one(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_ld = 0; m_n = 0; m_acc = 0; m_len = 8;
        e_wr = 0; e_busy = 0; e_done = 0; e_abt = 0; e_ovf = 0; e_tm = 0;
        e_data = '0; e_bl = '0;
    endtask

    task automatic model_edge();
        bit idle, accept, set_ovf, set_tm;
        if (!rst_n) return;
        idle    = !m_act && !e_done;
        accept  = idle && trigger && armed;
        set_tm  = !idle && trigger;
        set_ovf = m_act && !m_ld && ifc.adc_valid && !ifc.fifo_ready;
        e_wr = 0; e_done = 0; e_abt = 0;
        if (accept) begin
            m_n = int'(num_fill_bursts); m_len = burst_sel_10 ? 10 : 8; m_acc = 0;
            m_act = 1; m_ld = 1; e_ovf = 0; e_tm = 0;
        end else if (m_act && abort) begin
            e_abt = 1; m_act = 0;
        end else if (m_act && m_ld) begin
            m_ld = 0;
            if (m_n == 0) begin m_act = 0; e_done = 1; end
        end else if (m_act && ifc.adc_valid && ifc.fifo_ready) begin
            e_wr = 1; e_data = ifc.adc_data; m_acc++;
            if (m_acc == m_n * m_len) begin m_act = 0; e_done = 1; end
        end
        if (set_ovf) e_ovf = 1; else if (clear_status) e_ovf = 0;
        if (set_tm) e_tm = 1; else if (clear_status) e_tm = 0;
        e_bl   = 21'(m_n - m_acc / m_len);
        e_busy = m_act;
    endtask

    task automatic check_all();
        check_one("fifo_wr", 32'(ifc.fifo_wr), 32'(e_wr));
        check_one("fifo_data", 32'(ifc.fifo_data), 32'(e_data));
        check_one("busy", 32'(busy), 32'(e_busy));
        check_one("fill_done", 32'(fill_done), 32'(e_done));
        check_one("fill_aborted", 32'(fill_aborted), 32'(e_abt));
        check_one("bursts_left", 32'(bursts_left), 32'(e_bl));
        check_one("overflow", 32'(overflow), 32'(e_ovf));
        check_one("trig_miss", 32'(trig_miss), 32'(e_tm));
    endtask

    task automatic clr_counts();
        wr_cnt = 0; busy_cnt = 0; done_cnt = 0; abt_cnt = 0; done_at_wr = -1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (ifc.fifo_wr === 1'b1) wr_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (fill_done === 1'b1) begin done_cnt++; done_at_wr = wr_cnt; end
        if (fill_aborted === 1'b1) abt_cnt++;
        ifc.adc_data = DATA_W'($urandom);
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1; step(); trigger = 1'b0;
    endtask

    task automatic run_until_wr(input int target);
        for (int i = 0; i < 200 && wr_cnt < target; i++) step();
        check_one("wr_reach", 32'(wr_cnt), 32'(target));
    endtask

    initial begin
        model_reset();
        clr_counts();
        ifc.adc_valid = 1'b0; ifc.adc_data = '0; ifc.fifo_ready = 1'b1;
        #12;
        check_all();
        rst_n = 1'b1;
        step();

        // Three 8-sample bursts, clean stream.
        armed = 1'b1; num_fill_bursts = 21'd3; burst_sel_10 = 1'b0;
        ifc.adc_valid = 1'b1; ifc.fifo_ready = 1'b1;
        clr_counts();
        pulse_trigger();
        for (int i = 0; i < 30; i++) step();
        check_one("t1_writes", 32'(wr_cnt), 32'd24);
        check_one("t1_busy_cycles", 32'(busy_cnt), 32'd25);
        check_one("t1_done_count", 32'(done_cnt), 32'd1);
        check_one("t1_done_at_wr", 32'(done_at_wr), 32'd24);
        check_one("t1_bursts_left", 32'(bursts_left), 32'd0);

        // Zero-burst fill: LOAD then DONE, no writes.
        num_fill_bursts = 21'd0;
        clr_counts();
        pulse_trigger();
        check_one("t2_load_busy", 32'(busy), 32'd1);
        step();
        check_one("t2_done_2cyc", 32'(fill_done), 32'd1);
        for (int i = 0; i < 3; i++) step();
        check_one("t2_writes", 32'(wr_cnt), 32'd0);
        check_one("t2_overflow", 32'(overflow), 32'd0);

        // Two 10-sample bursts with FIFO back-pressure mid-fill.
        num_fill_bursts = 21'd2; burst_sel_10 = 1'b1;
        clr_counts();
        pulse_trigger();
        for (int i = 0; i < 6; i++) step();
        ifc.fifo_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        ifc.fifo_ready = 1'b1;
        for (int i = 0; i < 30; i++) step();
        check_one("t3_writes", 32'(wr_cnt), 32'd20);
        check_one("t3_overflow_sticky", 32'(overflow), 32'd1);
        clear_status = 1'b1; step(); clear_status = 1'b0;
        check_one("t3_overflow_clr", 32'(overflow), 32'd0);

        // Re-trigger during fill: flagged, fill length unchanged.
        num_fill_bursts = 21'd2; burst_sel_10 = 1'b0;
        clr_counts();
        pulse_trigger();
        run_until_wr(5);
        pulse_trigger();
        check_one("t4_trig_miss", 32'(trig_miss), 32'd1);
        for (int i = 0; i < 30; i++) step();
        check_one("t4_writes", 32'(wr_cnt), 32'd16);
        check_one("t4_done", 32'(done_cnt), 32'd1);

        // Abort at the 13th write of a 4x8 fill.
        num_fill_bursts = 21'd4;
        clr_counts();
        pulse_trigger();
        run_until_wr(13);
        abort = 1'b1; step(); abort = 1'b0;
        check_one("t5_aborted", 32'(fill_aborted), 32'd1);
        check_one("t5_busy", 32'(busy), 32'd0);
        check_one("t5_bursts_left", 32'(bursts_left), 32'd3);
        for (int i = 0; i < 5; i++) step();
        check_one("t5_writes", 32'(wr_cnt), 32'd13);
        check_one("t5_no_done", 32'(done_cnt), 32'd0);
        check_one("t5_abort_pulses", 32'(abt_cnt), 32'd1);
        num_fill_bursts = 21'd1;
        clr_counts();
        pulse_trigger();
        for (int i = 0; i < 15; i++) step();
        check_one("t5_refill_writes", 32'(wr_cnt), 32'd8);
        check_one("t5_refill_done", 32'(done_cnt), 32'd1);

        // Asynchronous reset in the middle of a fill.
        num_fill_bursts = 21'd3;
        pulse_trigger();
        for (int i = 0; i < 10; i++) step();
        #2 rst_n = 1'b0;
        #1;
        check_one("t6_rst_busy", 32'(busy), 32'd0);
        check_one("t6_rst_bursts", 32'(bursts_left), 32'd0);
        check_one("t6_rst_wr", 32'(ifc.fifo_wr), 32'd0);
        check_one("t6_rst_data", 32'(ifc.fifo_data), 32'd0);
        model_reset();
        step(); step();
        #2 rst_n = 1'b1;
        armed = 1'b0;
        clr_counts();
        pulse_trigger();
        step();
        check_one("t6_unarmed_busy", 32'(busy), 32'd0);
        check_one("t6_unarmed_miss", 32'(trig_miss), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            armed           = ($urandom_range(0, 9) != 0);
            trigger         = ($urandom_range(0, 19) == 0);
            abort           = ($urandom_range(0, 79) == 0);
            clear_status    = ($urandom_range(0, 29) == 0);
            num_fill_bursts = CNT_W'($urandom_range(0, 3));
            burst_sel_10    = 1'($urandom);
            ifc.adc_valid   = ($urandom_range(0, 3) != 0);
            ifc.fifo_ready  = ($urandom_range(0, 7) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
